clock_display_scanner: RTL and testbench
========================================

Name: clock_display_scanner

Overview:
- Reads the 24-bit BCD time bus (HH:MM:SS) produced by the 24-hour clock counter and drives a 6-digit multiplexed seven-segment display.
- Snapshots time on a valid strobe and applies it only at frame boundaries, so a displayed frame never mixes two times.
- Inserts a blanking gap between digits to prevent ghosting.
- Sits between the clock core and board-level display pins.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit is shown (min 2).
- BLANK_CYCLES, 4, clk cycles all anodes are off between digits (min 1, less than SCAN_DIV).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  1 = scan; 0 = freeze scan state and blank outputs.
- time_in  input  24  BCD time: [23:20] hours tens, [19:16] hours ones, [15:12] minutes tens, [11:8] minutes ones, [7:4] seconds tens, [3:0] seconds ones.
- time_valid  input  1  one-cycle strobe; capture time_in.
- seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point (separator).
- an  output  6  active-low digit anodes; an[i] selects digit i.
- frame_done  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (rst=0, async):
  - an=6'b111111, seg=7'b1111111, dp=1, frame_done=0.
  - idx=0, FSM in BLANK, prescaler=0, display and pending registers=0, pending flag=0.
- Digit order: idx 0 = seconds ones ... idx 5 = hours tens (nibble idx*4+3 : idx*4).
- FSM has two states:
  - BLANK: an all 1, seg all 1, dp=1. Count BLANK_CYCLES cycles, then go to SHOW with the counter cleared.
  - SHOW: an[idx]=0, all other anodes 1. seg = decode(display nibble idx). dp=0 when idx is 2 or 4, else 1. Count SCAN_DIV cycles; on the last cycle go to BLANK.
    - idx<5: idx increments.
    - idx==5: idx wraps to 0 and frame_done=1 for that cycle.
- All outputs are registered. Each SHOW dwell is exactly SCAN_DIV cycles and each BLANK gap exactly BLANK_CYCLES cycles, so one frame = 6*(SCAN_DIV+BLANK_CYCLES) cycles.
- Snapshot:
  - time_valid=1: pending <= time_in, pending flag <= 1.
  - At frame wrap (same cycle frame_done is asserted): if the flag is set, display <= pending and the flag clears.
  - time_valid on the wrap cycle itself: display <= time_in directly (newest wins) and the flag stays clear.
  - Multiple strobes within one frame: the last one wins.
- Decode:
  - Nibbles 0-9 map to standard active-low glyphs.
  - Nibbles 10-15 show a dash (seg=7'b0111111).
  - No range checking of the time itself (e.g. hours 25 displays as-is).
- enable=0:
  - Outputs go to the blank values on the next edge.
  - Prescaler, FSM state and idx hold; frame_done=0.
  - Snapshot capture still operates.
  - Re-enable resumes exactly where scanning stopped.
- Reset mid-frame: immediate return to reset values; the pending time is lost.
- Counter width: $clog2(SCAN_DIV); the same counter is reused for BLANK.

Optional Feature:
- Macro CLOCK_DISPLAY_LEAD_ZERO_BLANK_EN.
- Defined: during SHOW with idx==5 and hours-tens nibble==0, an stays 6'b111111, seg=7'b1111111 and dp=1. Timing is unchanged (dwell still SCAN_DIV cycles).
- Undefined: a hours-tens zero is displayed as "0".

Decomposition:
- Package clock_display_pkg:
  - NUM_DIGITS=6.
  - SEG_DIGIT[0:9] glyph constants, SEG_DASH, SEG_OFF=7'b1111111, AN_OFF.
  - State typedef {BLANK, SHOW}.
  - Separator digit indices (2, 4).
- One combinational sub-module bcd_to_seg7 (4-bit in, 7-bit out, dash for >9), instantiated once for the selected nibble.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=1):
- Reset then release with time_valid pulse time_in=24'h235947 -> display register loads at the first wrap. Second frame shows digits in order 7,4,9,5,3,2 with an one-hot low and 4 SHOW cycles each, 1 all-off cycle between digits. dp low on idx 2 and 4 only. frame_done pulses every 30 cycles.
- Strobe 24'h120000, then 24'h130000, both mid-frame -> the next frame shows 13:00:00 and never 12.
- Strobe 24'h010203 exactly on the frame_done cycle -> the following frame shows 01:02:03 and the pending flag stays 0.
- time_in=24'h00000A -> idx0 seg=7'b0111111 (dash).
- Deassert enable for 10 cycles mid-SHOW of idx 3 -> outputs blank, idx stays 3; after re-enable, the remaining dwell completes and the full frame period is extended by exactly 10 cycles.
- rst low mid-SHOW asynchronously -> outputs blank before the next clk edge. With the macro defined and time 24'h091500, idx5 shows blank anodes for its 4-cycle dwell.

Source files
------------

// File: rtl/clock_display_pkg.sv
// Shared constants and types for the six-digit multiplexed clock display.
package clock_display_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned TIME_W     = 24;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [SEG_W-1:0]      SEG_DASH = 7'h3F;
    localparam logic [SEG_W-1:0]      SEG_OFF  = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = 6'h3F;

    // Separator dots sit after the hours and minutes pairs
    localparam logic [IDX_W-1:0] SEP_IDX_A = 3'd2;
    localparam logic [IDX_W-1:0] SEP_IDX_B = 3'd4;
    localparam logic [IDX_W-1:0] LAST_IDX  = 3'd5;

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

endpackage

// File: rtl/clock_display_scanner_bcd_to_seg7.sv
// BCD nibble to active-low seven-segment glyph; values above 9 show a dash.
module bcd_to_seg7
    import clock_display_pkg::*;
(
    input  logic [NIB_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_DIGIT[0];
            4'd1: seg = SEG_DIGIT[1];
            4'd2: seg = SEG_DIGIT[2];
            4'd3: seg = SEG_DIGIT[3];
            4'd4: seg = SEG_DIGIT[4];
            4'd5: seg = SEG_DIGIT[5];
            4'd6: seg = SEG_DIGIT[6];
            4'd7: seg = SEG_DIGIT[7];
            4'd8: seg = SEG_DIGIT[8];
            4'd9: seg = SEG_DIGIT[9];
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_scanner.sv
// Scans a snapshotted BCD HH:MM:SS time onto a 6-digit multiplexed display.
// Optional macro CLOCK_DISPLAY_LEAD_ZERO_BLANK_EN blanks a leading hours-tens zero.
module clock_display_scanner
    import clock_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [TIME_W-1:0]     time_in,
    input  logic                  time_valid,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_done
);

    localparam int unsigned CW = $clog2(SCAN_DIV);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [IDX_W-1:0]    idx;
    logic [TIME_W-1:0]   display;
    logic [TIME_W-1:0]   pending;
    logic                pend_flag;

    logic [NIB_W-1:0]      nib_c;
    logic [SEG_W-1:0]      glyph_c;
    logic                  lead_blank_c;
    logic [NUM_DIGITS-1:0] show_an_c;
    logic [SEG_W-1:0]      show_seg_c;
    logic                  show_dp_c;
    logic                  show_last_c;
    logic                  wrap_c;

    assign nib_c = NIB_W'(display >> {idx, 2'b00});

    bcd_to_seg7 u_dec (
        .bcd (nib_c),
        .seg (glyph_c)
    );

`ifdef CLOCK_DISPLAY_LEAD_ZERO_BLANK_EN
    assign lead_blank_c = (idx == LAST_IDX) && (display[23:20] == 4'd0);
`else
    assign lead_blank_c = 1'b0;
`endif

    // Output values for the digit currently selected by idx
    assign show_an_c  = lead_blank_c ? AN_OFF : (AN_OFF ^ (NUM_DIGITS'(1) << idx));
    assign show_seg_c = lead_blank_c ? SEG_OFF : glyph_c;
    assign show_dp_c  = lead_blank_c ? 1'b1
                                     : !((idx == SEP_IDX_A) || (idx == SEP_IDX_B));

    assign show_last_c = (cnt == CW'(SCAN_DIV - 1));
    assign wrap_c      = enable && (state == SHOW) && show_last_c && (idx == LAST_IDX);

    // Time snapshot: applied only at the frame wrap so a frame never mixes times
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            display   <= '0;
            pending   <= '0;
            pend_flag <= 1'b0;
        end else if (wrap_c) begin
            pend_flag <= 1'b0;
            if (time_valid) begin
                display <= time_in;
            end else if (pend_flag) begin
                display <= pending;
            end
        end else if (time_valid) begin
            pending   <= time_in;
            pend_flag <= 1'b1;
        end
    end

    // Scan FSM; outputs are registered from the state being entered so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else if (!enable) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                BLANK: begin
                    if (cnt == CW'(BLANK_CYCLES - 1)) begin
                        state <= SHOW;
                        cnt   <= '0;
                        an    <= show_an_c;
                        seg   <= show_seg_c;
                        dp    <= show_dp_c;
                    end else begin
                        cnt <= cnt + CW'(1);
                        an  <= AN_OFF;
                        seg <= SEG_OFF;
                        dp  <= 1'b1;
                    end
                end
                SHOW: begin
                    if (show_last_c) begin
                        state <= BLANK;
                        cnt   <= '0;
                        idx   <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                        an    <= AN_OFF;
                        seg   <= SEG_OFF;
                        dp    <= 1'b1;
                    end else begin
                        cnt        <= cnt + CW'(1);
                        an         <= show_an_c;
                        seg        <= show_seg_c;
                        dp         <= show_dp_c;
                        // Pulse lands on the final dwell cycle of the last digit
                        frame_done <= (idx == LAST_IDX) && (cnt == CW'(SCAN_DIV - 2));
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_display_scanner.sv
// Directed self-checking bench for clock_display_scanner with SCAN_DIV=4, BLANK_CYCLES=1.
module tb_clock_display_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] time_in;
    logic        time_valid;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  an;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    clock_display_scanner #(
        .SCAN_DIV     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .time_in    (time_in),
        .time_valid (time_valid),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Packed {an, seg, dp, frame_done}
    function automatic logic [31:0] obs();
        return 32'({an, seg, dp, frame_done});
    endfunction

    function automatic logic [31:0] show_exp(input logic [23:0] t, input int d, input logic fd);
        logic [3:0] nib;
        logic [5:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        nib   = 4'((t >> (4 * d)) & 24'hF);
        an_e  = ~(6'b000001 << d);
        seg_e = glyph(nib);
        dp_e  = !(d == 2 || d == 4);
`ifdef CLOCK_DISPLAY_LEAD_ZERO_BLANK_EN
        if (d == 5 && nib == 4'd0) begin
            an_e  = 6'h3F;
            seg_e = 7'h7F;
            dp_e  = 1'b1;
        end
`endif
        return 32'({an_e, seg_e, dp_e, fd});
    endfunction

    localparam logic [31:0] BLANK_EXP = 32'({6'h3F, 7'h7F, 1'b1, 1'b0});

    task automatic strobe(input logic [23:0] t);
        time_in    = t;
        time_valid = 1'b1;
        @(negedge clk);
        time_valid = 1'b0;
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        chk("frame_done_wait", 32'(frame_done), 32'd1);
    endtask

    // Called on the frame_done cycle; checks the whole next frame cycle by cycle
    task automatic check_frame(input logic [23:0] t);
        for (int d = 0; d < 6; d++) begin
            @(negedge clk);
            time_valid = 1'b0;
            chk($sformatf("blank_t%06h_d%0d", t, d), obs(), BLANK_EXP);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk($sformatf("show_t%06h_d%0d_k%0d", t, d, k), obs(),
                    show_exp(t, d, (d == 5 && k == 3)));
            end
        end
    endtask

    initial begin
        int n;
        rst        = 1'b0;
        enable     = 1'b1;
        time_valid = 1'b0;
        time_in    = 24'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", obs(), BLANK_EXP);

        // Release with a strobe; first frame still shows zeros
        rst        = 1'b1;
        time_in    = 24'h235947;
        time_valid = 1'b1;
        @(negedge clk);
        time_valid = 1'b0;
        chk("first_digit_zero", obs(), 32'({6'b111110, 7'b1000000, 1'b1, 1'b0}));
        wait_fd();
        check_frame(24'h235947);

        // Two strobes mid-frame: the last one wins
        repeat (5) @(negedge clk);
        strobe(24'h120000);
        repeat (3) @(negedge clk);
        strobe(24'h130000);
        wait_fd();
        check_frame(24'h130000);

        // Strobe on the frame_done cycle loads directly at the wrap
        time_in    = 24'h010203;
        time_valid = 1'b1;
        check_frame(24'h010203);

        // Out-of-range nibbles show a dash
        repeat (3) @(negedge clk);
        strobe(24'h00000A);
        wait_fd();
        check_frame(24'h00000A);
        repeat (3) @(negedge clk);
        strobe(24'h68F10B);
        wait_fd();
        check_frame(24'h68F10B);

        // Pause for 10 cycles during the idx 3 dwell
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 18 || n == 29)
                chk($sformatf("idx3_show_n%0d", n), obs(), show_exp(24'h68F10B, 3, 1'b0));
            if (n >= 19 && n <= 28)
                chk($sformatf("paused_n%0d", n), obs(), BLANK_EXP);
            if (n == 18) enable = 1'b0;
            if (n == 28) enable = 1'b1;
        end while (!frame_done && n < 100);
        chk("paused_frame_period", 32'(n), 32'd40);

        // Leading hours-tens zero
        repeat (3) @(negedge clk);
        strobe(24'h091500);
        wait_fd();
        check_frame(24'h091500);

        // Async reset mid-dwell drops the pending time
        repeat (3) @(negedge clk);
        strobe(24'h111111);
        repeat (3) @(negedge clk);
        chk("pre_reset_idx1", obs(), show_exp(24'h091500, 1, 1'b0));
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", obs(), BLANK_EXP);
        @(negedge clk);
        rst = 1'b1;
        wait_fd();
        check_frame(24'h000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
